// File: rtl/pl_multiclass_eval.sv
// Multi-class pseudo-linear classifier evaluator.
// Accepts one binarised image, accumulates per-class masked-hit and mask
// popcounts CHUNK bits per cycle, then compares (mask_count >> threshold)
// against the hit count for every class and holds the fire vector until
// the consumer takes it.
module pl_multiclass_eval #(
    parameter int IMG_W   = 784,
    parameter int N_CLASS = 10,
    parameter int CHUNK   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IMG_W-1:0]               image,
    input  logic [3:0]                     threshold,
    input  logic [N_CLASS*IMG_W-1:0]       pm_flat,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_CLASS-1:0]             result,
    output logic [$clog2(N_CLASS+1)-1:0]   fire_count,
    output logic                           onehot
);

    localparam int NCHUNK = (IMG_W + CHUNK - 1) / CHUNK;
    localparam int CNT_W  = $clog2(IMG_W + 1);
    localparam int FC_W   = $clog2(N_CLASS + 1);
    localparam int PAD_W  = NCHUNK * CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CMP   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Number of set bits in one slice, sized to the accumulator width.
    function automatic logic [CNT_W-1:0] popcnt_chunk(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Number of classes that fired.
    function automatic logic [FC_W-1:0] popcnt_res(input logic [N_CLASS-1:0] v);
        logic [FC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            c = c + FC_W'(v[i]);
        end
        return c;
    endfunction

    state_t                 state_q, state_d;
    logic [IMG_W-1:0]       img_q, img_d;
    logic [3:0]             thr_q, thr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       acc_hit_q [N_CLASS];
    logic [CNT_W-1:0]       acc_hit_d [N_CLASS];
    logic [CNT_W-1:0]       acc_msk_q [N_CLASS];
    logic [CNT_W-1:0]       acc_msk_d [N_CLASS];
    logic [N_CLASS-1:0]     result_q, result_d;
    logic [FC_W-1:0]        fire_count_q, fire_count_d;
    logic                   onehot_q, onehot_d;

    int                     base_s;
    logic [PAD_W-1:0]       img_pad_s;
    logic [PAD_W-1:0]       msk_pad_s;
    logic [CHUNK-1:0]       img_slice_s;
    logic [CHUNK-1:0]       msk_slice_s;
    logic [CNT_W-1:0]       hit_inc_s [N_CLASS];
    logic [CNT_W-1:0]       msk_inc_s [N_CLASS];

    // Current slice of image and masks; bits beyond IMG_W read as zero.
    always_comb begin
        base_s      = int'(idx_q) * CHUNK;
        img_pad_s   = '0;
        img_pad_s[IMG_W-1:0] = img_q;
        img_slice_s = img_pad_s[base_s +: CHUNK];
        msk_pad_s   = '0;
        msk_slice_s = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            msk_pad_s            = '0;
            msk_pad_s[IMG_W-1:0] = pm_flat[k*IMG_W +: IMG_W];
            msk_slice_s          = msk_pad_s[base_s +: CHUNK];
            hit_inc_s[k]         = popcnt_chunk(msk_slice_s & img_slice_s);
            msk_inc_s[k]         = popcnt_chunk(msk_slice_s);
        end
    end

    // Next-state and datapath update for the accept/accumulate/compare/hold sequence.
    always_comb begin
        state_d      = state_q;
        img_d        = img_q;
        thr_d        = thr_q;
        idx_d        = idx_q;
        acc_hit_d    = acc_hit_q;
        acc_msk_d    = acc_msk_q;
        result_d     = result_q;
        fire_count_d = fire_count_q;
        onehot_d     = onehot_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    img_d   = image;
                    thr_d   = threshold;
                    idx_d   = '0;
                    for (int k = 0; k < N_CLASS; k++) begin
                        acc_hit_d[k] = '0;
                        acc_msk_d[k] = '0;
                    end
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                for (int k = 0; k < N_CLASS; k++) begin
                    acc_hit_d[k] = acc_hit_q[k] + hit_inc_s[k];
                    acc_msk_d[k] = acc_msk_q[k] + msk_inc_s[k];
                end
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    state_d = CMP;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            CMP: begin
                // A shift of CNT_W or more yields zero, so such a class only fires on zero hits.
                for (int k = 0; k < N_CLASS; k++) begin
                    result_d[k] = ((acc_msk_q[k] >> thr_q) >= acc_hit_q[k]);
                end
                fire_count_d = popcnt_res(result_d);
                onehot_d     = (fire_count_d == FC_W'(1));
                state_d      = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched inputs, accumulators and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            img_q        <= '0;
            thr_q        <= 4'd0;
            idx_q        <= '0;
            for (int k = 0; k < N_CLASS; k++) begin
                acc_hit_q[k] <= '0;
                acc_msk_q[k] <= '0;
            end
            result_q     <= '0;
            fire_count_q <= '0;
            onehot_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            img_q        <= img_d;
            thr_q        <= thr_d;
            idx_q        <= idx_d;
            acc_hit_q    <= acc_hit_d;
            acc_msk_q    <= acc_msk_d;
            result_q     <= result_d;
            fire_count_q <= fire_count_d;
            onehot_q     <= onehot_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign result     = result_q;
    assign fire_count = fire_count_q;
    assign onehot     = onehot_q;

endmodule

// File: tb/tb_pl_multiclass_eval.sv
// Self-checking bench for pl_multiclass_eval: directed corner cases plus
// randomized images/masks compared against a bit-counting reference model.
module tb_pl_multiclass_eval;

    localparam int IMG_W   = 784;
    localparam int N_CLASS = 10;
    localparam int CHUNK   = 16;
    localparam int FC_W    = 4;
    localparam int LAT     = 50;

    localparam int S_IMG_W = 20;
    localparam int S_N     = 2;
    localparam int S_CHUNK = 8;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [IMG_W-1:0]           image;
    logic [3:0]                 threshold;
    logic [N_CLASS*IMG_W-1:0]   pm_flat;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_CLASS-1:0]         result;
    logic [FC_W-1:0]            fire_count;
    logic                       onehot;

    logic                       s_in_valid, s_in_ready, s_busy, s_out_valid, s_out_ready, s_onehot;
    logic [S_IMG_W-1:0]         s_image;
    logic [3:0]                 s_threshold;
    logic [S_N*S_IMG_W-1:0]     s_pm_flat;
    logic [S_N-1:0]             s_result;
    logic [1:0]                 s_fire_count;

    int n_checks = 0;
    int n_errors = 0;

    pl_multiclass_eval #(.IMG_W(IMG_W), .N_CLASS(N_CLASS), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .image(image), .threshold(threshold), .pm_flat(pm_flat), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .fire_count(fire_count), .onehot(onehot)
    );

    pl_multiclass_eval #(.IMG_W(S_IMG_W), .N_CLASS(S_N), .CHUNK(S_CHUNK)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .image(s_image), .threshold(s_threshold), .pm_flat(s_pm_flat), .busy(s_busy),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
        .fire_count(s_fire_count), .onehot(s_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: count mask bits and overlapping image bits over the whole width.
    function automatic logic [N_CLASS-1:0] ref_result(input logic [IMG_W-1:0] img,
                                                      input logic [N_CLASS*IMG_W-1:0] pm,
                                                      input int thr);
        logic [N_CLASS-1:0] r;
        int hit, msk;
        r = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            hit = 0;
            msk = 0;
            for (int i = 0; i < IMG_W; i++) begin
                if (pm[k*IMG_W + i]) begin
                    msk++;
                    if (img[i]) hit++;
                end
            end
            r[k] = ((msk >> thr) >= hit);
        end
        return r;
    endfunction

    function automatic int ones(input logic [N_CLASS-1:0] v);
        int c = 0;
        for (int i = 0; i < N_CLASS; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [IMG_W-1:0] rand_bits(input int pct);
        logic [IMG_W-1:0] v;
        for (int i = 0; i < IMG_W; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    task automatic rand_masks(input int pct);
        for (int i = 0; i < N_CLASS*IMG_W; i++) pm_flat[i] = ($urandom_range(0, 99) < pct);
    endtask

    // Submit one image from a negedge, wait for out_valid, compare with the model.
    // Leaves the DUT in HOLD with out_ready low.
    task automatic run_img(input string tag, input logic [IMG_W-1:0] img, input logic [3:0] thr);
        logic [N_CLASS-1:0] exp;
        int cnt;
        exp       = ref_result(img, pm_flat, int'(thr));
        in_valid  = 1'b1;
        image     = img;
        threshold = thr;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        image     = rand_bits(50);
        threshold = 4'($urandom_range(0, 15));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(LAT));
        chk({tag, "_result"}, 64'(result), 64'(exp));
        chk({tag, "_fire_count"}, 64'(fire_count), 64'(ones(exp)));
        chk({tag, "_onehot"}, 64'(onehot), 64'(ones(exp) == 1));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_small(input string tag, input logic [S_IMG_W-1:0] img,
                             input logic [3:0] thr, input logic [S_N-1:0] exp);
        int cnt;
        s_in_valid  = 1'b1;
        s_image     = img;
        s_threshold = thr;
        @(negedge clk);
        s_in_valid  = 1'b0;
        cnt = 0;
        while (!s_out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'd4);
        chk({tag, "_result"}, 64'(s_result), 64'(exp));
        chk({tag, "_fire_count"}, 64'(s_fire_count), 64'(int'(exp[0]) + int'(exp[1])));
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    logic [IMG_W-1:0]   img_v;
    logic [N_CLASS-1:0] hold_res;
    logic [FC_W-1:0]    hold_fc;
    logic               hold_oh;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; image = '0; threshold = 4'd0; pm_flat = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_image = '0; s_threshold = 4'd0; s_pm_flat = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_fire_count", 64'(fire_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero masks: every class fires.
        pm_flat = '0;
        run_img("zero_mask", rand_bits(50), 4'd2);
        chk("zero_mask_all", 64'(result), 64'h3FF);
        chk("zero_mask_fc10", 64'(fire_count), 64'd10);
        release_out("zero_mask");

        // Class 3 with 8 mask bits; overlap 2 fires, overlap 3 does not.
        pm_flat = '0;
        for (int j = 0; j < 8; j++) pm_flat[3*IMG_W + 200 + 5*j] = 1'b1;
        img_v = '0;
        img_v[200] = 1'b1; img_v[205] = 1'b1; img_v[600] = 1'b1;
        run_img("c3_ov2", img_v, 4'd2);
        chk("c3_ov2_bit", 64'(result[3]), 64'd1);
        release_out("c3_ov2");
        img_v[210] = 1'b1;
        run_img("c3_ov3", img_v, 4'd2);
        chk("c3_ov3_all", 64'(result), 64'h3F7);
        chk("c3_ov3_fc", 64'(fire_count), 64'd9);
        release_out("c3_ov3");

        // Class 0 with only bit 0: threshold 0 fires, threshold 15 does not.
        pm_flat = '0;
        pm_flat[0] = 1'b1;
        img_v = '0;
        img_v[0] = 1'b1;
        run_img("b0_t0", img_v, 4'd0);
        chk("b0_t0_bit", 64'(result[0]), 64'd1);
        release_out("b0_t0");
        run_img("b0_t15", img_v, 4'd15);
        chk("b0_t15_bit", 64'(result[0]), 64'd0);
        release_out("b0_t15");

        // Backpressure: outputs frozen and new images ignored while in HOLD.
        rand_masks(30);
        run_img("bp", rand_bits(40), 4'd1);
        hold_res = result; hold_fc = fire_count; hold_oh = onehot;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            image    = rand_bits(50);
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_result", 64'(result), 64'(hold_res));
            chk("bp_fire_count", 64'(fire_count), 64'(hold_fc));
            chk("bp_onehot", 64'(onehot), 64'(hold_oh));
        end
        in_valid = 1'b0;
        release_out("bp");
        @(negedge clk);
        chk("bp_not_queued", 64'(busy), 64'd0);

        // Reset in the middle of accumulation, then a clean evaluation.
        rand_masks(25);
        run_img("pre_rst", rand_bits(30), 4'd1);
        release_out("pre_rst");
        in_valid = 1'b1; image = rand_bits(60); threshold = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_fire_count", 64'(fire_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        run_img("post_rst", rand_bits(25), 4'd1);
        release_out("post_rst");

        // Randomized images, masks and thresholds.
        for (int t = 0; t < 8; t++) begin
            rand_masks($urandom_range(5, 60));
            run_img("rand", rand_bits($urandom_range(5, 80)),
                    (t == 7) ? 4'd12 : 4'($urandom_range(0, 3)));
            release_out("rand");
        end

        // Reduced-size instance: padding bits in the last slice must not count.
        s_pm_flat = '1;
        run_small("small_ones", '1, 4'd0, 2'b11);
        run_small("small_pad", 20'h007FF, 4'd1, 2'b00);
        run_small("small_pad10", 20'h003FF, 4'd1, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
